// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to sequential word addresses, and holds the
// core in reset until the program has been loaded.
module im_loader #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        byte_idx;
   logic [31:0]       asm_word;
   logic [31:0]       asm_merged;
   logic              last_word;
   logic              xfer;
   logic              word_end;
   logic              at_top;

   // Handshake decode, byte-lane merge and next-state selection
   always_comb begin
      state_nxt  = state;
      byte_ready = (state == S_LOAD);
      xfer       = byte_valid && (state == S_LOAD);
      asm_merged = asm_word | ({24'b0, byte_in} << {byte_idx, 3'b000});
      word_end   = xfer && ((byte_idx == 2'd3) || byte_last);
      at_top     = (addr == ADDR_W'(DEPTH - 1));
      case (state)
         S_IDLE,
         S_DONE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (word_end) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (last_word || at_top) state_nxt = S_DONE;
            else                     state_nxt = S_LOAD;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Datapath and registered outputs; strobes are derived from the next
   // state so they line up with the cycle the FSM occupies that state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr      <= '0;
         byte_idx  <= '0;
         asm_word  <= '0;
         last_word <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         overflow  <= 1'b0;
         word_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE,
            S_DONE: begin
               if (start) begin
                  addr      <= '0;
                  word_cnt  <= '0;
                  byte_idx  <= '0;
                  asm_word  <= '0;
                  last_word <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  if (word_end) begin
                     wr_data   <= asm_merged;
                     wr_addr   <= addr;
                     last_word <= byte_last;
                  end else begin
                     asm_word <= asm_merged;
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            S_WRITE: begin
               addr     <= addr + 1'b1;
               word_cnt <= word_cnt + 1'b1;
               byte_idx <= '0;
               asm_word <= '0;
               if (!last_word && at_top) overflow <= 1'b1;
            end
            default: ;
         endcase
         wr_en    <= (state_nxt == S_WRITE);
         done     <= (state_nxt == S_DONE);
         cpu_hold <= (state_nxt != S_DONE);
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: randomized byte streams checked every cycle against
// a transaction-level model, plus literal expectations for known programs.
module tb_im_loader;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_valid = 1'b0;
   logic              byte_last = 1'b0;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              overflow;
   logic [ADDR_W:0]   word_cnt;

   im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
      .done(done), .overflow(overflow), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a load is either active (accepting bytes or spending
   // one cycle writing a finished word) or not; completed words go out in order.
   bit          m_busy, m_bubble, m_done, m_ovf, m_lastw;
   int          m_cnt, m_addr;
   logic [31:0] m_data;
   logic [7:0]  m_bytes[$];
   int          obs_addr[$];
   logic [31:0] obs_data[$];

   always @(negedge clk) begin
      if (!rst) begin
         m_busy = 0; m_bubble = 0; m_done = 0; m_ovf = 0; m_lastw = 0;
         m_cnt = 0; m_addr = 0; m_data = '0;
         m_bytes.delete();
      end else begin
         chk("byte_ready", byte_ready, m_busy && !m_bubble);
         chk("wr_en", wr_en, m_bubble);
         chk("wr_data", wr_data, m_data);
         if (m_bubble) chk("wr_addr", wr_addr, m_addr);
         chk("done", done, m_done);
         chk("cpu_hold", cpu_hold, !m_done);
         chk("overflow", overflow, m_ovf);
         chk("word_cnt", word_cnt, m_cnt);
         if (wr_en) begin
            obs_addr.push_back(int'(wr_addr));
            obs_data.push_back(wr_data);
         end
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_done = 0; m_ovf = 0; m_cnt = 0; m_addr = 0;
               m_bytes.delete();
            end
         end else if (m_bubble) begin
            m_bubble = 0;
            m_cnt++;
            m_addr++;
            if (m_lastw) begin
               m_busy = 0; m_done = 1;
            end else if (m_cnt == DEPTH) begin
               m_busy = 0; m_done = 1; m_ovf = 1;
            end
         end else if (byte_valid) begin
            m_bytes.push_back(byte_in);
            if (m_bytes.size() == 4 || byte_last) begin
               m_data = '0;
               foreach (m_bytes[k]) m_data = m_data | (32'(m_bytes[k]) << (8 * k));
               m_lastw  = byte_last;
               m_bubble = 1;
               m_bytes.delete();
            end
         end
      end
   end

   logic [7:0] tx[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int budget = 50;
      bit acc;
      bit ok = 0;
      byte_in = b; byte_valid = 1'b1; byte_last = last;
      while (budget > 0 && !ok) begin
         @(negedge clk);
         acc = byte_ready;
         tick();
         ok = acc;
         budget--;
      end
      byte_valid = 1'b0; byte_last = 1'b0;
      if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_stream(input int max_gap, input bit mark_last);
      for (int i = 0; i < tx.size(); i++) begin
         repeat ($urandom_range(max_gap, 0)) tick();
         send_byte(tx[i], mark_last && (i == tx.size() - 1));
      end
   endtask

   task automatic wait_done();
      int budget = 3000;
      while (done !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_byte_ready"}, byte_ready, 0);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_cpu_hold"}, cpu_hold, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_word_cnt"}, word_cnt, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_w[$];
      int          n;
      #2 rst = 1'b0;
      #1 chk_reset_values("reset");
      #10;
      @(posedge clk); #1 rst = 1'b1;
      tick();

      // Two full words
      clear_obs();
      pulse_start();
      tx = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
      send_stream(0, 1);
      wait_done();
      chk("t1_nwr", obs_addr.size(), 2);
      if (obs_addr.size() == 2) begin
         chk("t1_a0", obs_addr[0], 0); chk("t1_d0", obs_data[0], 32'h00100013);
         chk("t1_a1", obs_addr[1], 1); chk("t1_d1", obs_data[1], 32'h00200093);
      end
      chk("t1_done", done, 1); chk("t1_hold", cpu_hold, 0);
      chk("t1_cnt", word_cnt, 2); chk("t1_ovf", overflow, 0);

      // Partial final word
      clear_obs();
      pulse_start();
      tx = '{8'h37, 8'h05, 8'h00, 8'h00, 8'hAA, 8'hBB};
      send_stream(0, 1);
      wait_done();
      chk("t2_nwr", obs_addr.size(), 2);
      if (obs_addr.size() == 2) begin
         chk("t2_d0", obs_data[0], 32'h00000537);
         chk("t2_a1", obs_addr[1], 1); chk("t2_d1", obs_data[1], 32'h0000BBAA);
      end
      chk("t2_done", done, 1); chk("t2_cnt", word_cnt, 2);

      // Same 3-word program without and with random valid gaps
      tx.delete();
      repeat (12) tx.push_back(8'($urandom));
      exp_w.delete();
      for (int w = 0; w < 3; w++)
         exp_w.push_back({tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]});
      for (int pass = 0; pass < 2; pass++) begin
         clear_obs();
         pulse_start();
         send_stream(pass * 5, 1);
         wait_done();
         chk("gap_nwr", obs_addr.size(), 3);
         for (int w = 0; w < obs_addr.size() && w < 3; w++) begin
            chk("gap_addr", obs_addr[w], w);
            chk("gap_data", obs_data[w], exp_w[w]);
         end
      end

      // Overflow: 64 words with no last marker
      clear_obs();
      pulse_start();
      tx.delete();
      repeat (4 * DEPTH) tx.push_back(8'($urandom));
      send_stream(0, 0);
      wait_done();
      chk("ovf_flag", overflow, 1); chk("ovf_done", done, 1);
      chk("ovf_cnt", word_cnt, DEPTH); chk("ovf_nwr", obs_addr.size(), DEPTH);
      if (obs_addr.size() == DEPTH) begin
         chk("ovf_last_addr", obs_addr[DEPTH-1], DEPTH - 1);
         chk("ovf_last_data", obs_data[DEPTH-1],
             {tx[4*DEPTH-1], tx[4*DEPTH-2], tx[4*DEPTH-3], tx[4*DEPTH-4]});
      end
      byte_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         byte_in = 8'($urandom);
         tick();
         chk("ovf_ready", byte_ready, 0);
      end
      byte_valid = 1'b0;
      chk("ovf_extra_wr", obs_addr.size(), DEPTH);

      // Reload from DONE, with a stray start mid-load
      clear_obs();
      pulse_start();
      chk("reload_done", done, 0); chk("reload_hold", cpu_hold, 1);
      send_byte(8'hEF, 1'b0);
      pulse_start();
      send_byte(8'hBE, 1'b0);
      send_byte(8'hAD, 1'b0);
      send_byte(8'hDE, 1'b1);
      wait_done();
      chk("reload_nwr", obs_addr.size(), 1);
      if (obs_addr.size() == 1) begin
         chk("reload_a0", obs_addr[0], 0); chk("reload_d0", obs_data[0], 32'hDEADBEEF);
      end
      chk("reload_ovf", overflow, 0); chk("reload_cnt", word_cnt, 1);

      // Random-length programs
      for (int r = 0; r < 4; r++) begin
         clear_obs();
         pulse_start();
         tx.delete();
         n = $urandom_range(40, 1);
         repeat (n) tx.push_back(8'($urandom));
         send_stream(2, 1);
         wait_done();
         chk("rand_nwr", obs_addr.size(), (n + 3) / 4);
      end

      // Asynchronous reset mid-word
      clear_obs();
      pulse_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      #1 rst = 1'b0;
      #1 chk_reset_values("midrst");
      tick();
      tick();
      rst = 1'b1;
      chk("midrst_nwr", obs_addr.size(), 0);
      pulse_start();
      tx = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_stream(0, 1);
      wait_done();
      chk("midrst_nwr2", obs_addr.size(), 1);
      if (obs_addr.size() == 1) begin
         chk("midrst_a0", obs_addr[0], 0); chk("midrst_d0", obs_data[0], 32'h04030201);
      end

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writes a program into the 64-word instruction memory from a byte stream before the multicycle RV32 core starts fetching.
- It is the write-side counterpart of the core's fetch path: it assembles little-endian bytes into 32-bit words, drives the memory write port with sequential word addresses, and holds the core in reset until loading completes.
- It sits between a byte source (UART receiver or testbench) and the instruction-memory write port. Its cpu_hold output feeds the core reset.

Parameters:
- ADDR_W, 6, word-address width; matches the 6-bit PC_out fetch address.
- DEPTH, 64, number of words in instruction memory; the last legal address is DEPTH-1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load at address 0. Honoured only in IDLE or DONE.
- byte_in  in  8  incoming program byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_last  in  1  qualifies byte_valid; this byte is the final byte of the program.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address for the write.
- wr_data  out  32  word to write.
- cpu_hold  out  1  1 = hold the core in reset.
- done  out  1  load finished; level output.
- overflow  out  1  program exceeded DEPTH words; sticky until the next start or reset.
- word_cnt  out  ADDR_W+1  number of words written in the current or most recent load.

Behaviour:
- Reset (rst=0, async) values: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, overflow=0, word_cnt=0, byte index=0, assembly register=0.
- All outputs are registered except byte_ready, which is decoded from state.
- States and transitions:
  - IDLE: byte_ready=0, cpu_hold=1. On start: go to LOAD, clear addr, word_cnt, byte index, assembly register, overflow.
  - LOAD: byte_ready=1, cpu_hold=1.
    - On transfer: byte k (index 0..3) goes into bits [8k+7:8k]; byte 0 lands in [7:0].
    - If k==3 or byte_last=1, go to WRITE. Lanes not yet filled are written as 0.
    - Otherwise increment the index.
    - Gaps in byte_valid are allowed and cause no state change.
  - WRITE: exactly one cycle. byte_ready=0; wr_en=1, wr_addr=addr, wr_data=assembled word.
    - On exit: addr+=1, word_cnt+=1, index=0, assembly register cleared.
    - If the word was marked last: go to DONE.
    - Else if addr==DEPTH-1: go to DONE with overflow=1.
    - Else: go to LOAD.
  - DONE: byte_ready=0, done=1, cpu_hold=0. Bytes are ignored. On start: behave as in IDLE (reload; done=0, cpu_hold=1 from the next cycle).
- Latency: wr_en asserts in the cycle after the transfer of a word's 4th (or last) byte. Minimum throughput is 5 cycles per word.
- start in LOAD or WRITE is ignored.
- byte_last with byte_valid=0 is ignored.
- Reset mid-load: everything returns to reset values immediately. No partial word is written; memory contents already written are left as-is.
- wr_addr never wraps. A write to DEPTH-1 that is not last terminates the load with overflow=1.
- Loading exactly DEPTH words with byte_last on the final byte gives done=1, overflow=0.
- word_cnt saturates at DEPTH by construction.
- wr_en=0 in every state except WRITE; wr_data holds its value when wr_en=0.

Test Plan:
- Reset, then start; send 8 bytes 13,00,10,00,93,00,20,00 (byte_last on the 8th) → writes: addr0=0x00100013, addr1=0x00200093. Then done=1, cpu_hold=0, word_cnt=2, overflow=0.
- Send 6 bytes 37,05,00,00,AA,BB with byte_last on BB → addr0=0x00000537, addr1=0x0000BBAA. done=1, word_cnt=2.
- Send 64 full words with no byte_last → the 64th write goes to addr 63, then overflow=1, done=1. A 65th word's bytes see byte_ready=0 and cause no wr_en.
- Insert random byte_valid gaps (0–5 idle cycles) during a 3-word load → same wr_data and addresses as the gap-free run; wr_en occurs exactly 3 times.
- Pull rst low after the 2nd byte of word 1 → all outputs return to reset values asynchronously; no wr_en; cpu_hold=1. After restart, the load begins at addr 0.
- In DONE, pulse start and load 1 word 0xDEADBEEF (bytes EF,BE,AD,DE, last) → done drops and cpu_hold=1 during the load; addr0=0xDEADBEEF; overflow is cleared. start pulsed during LOAD has no effect.
